// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_ctrl
// Purpose  : Register-file write-back arbiter (load responses vs execute
//            results) with an in-order load tag FIFO and a hazard scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_wb_ctrl #(
    parameter int LD_DEPTH      = 4,
    parameter int MAX_LD_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    output logic        issue_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic [4:0]  rs1_index,
    input  logic [4:0]  rs2_index,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_w,
    output logic [4:0]  rd_index,
    output logic [31:0] rd_in,
    output logic        proto_err
);

    localparam int c_ptr_w = $clog2(LD_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_str_w = $clog2(MAX_LD_STREAK + 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt   = c_cnt_w'(LD_DEPTH);
    localparam logic [c_str_w-1:0] c_streak_max = c_str_w'(MAX_LD_STREAK);

    logic [4:0]         fifo_q [LD_DEPTH];
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_str_w-1:0] streak_q, streak_d;
    logic               perr_q, perr_d;

    logic               w_full, w_empty;
    logic [4:0]         w_head;
    logic [LD_DEPTH-1:0] w_ent_valid;
    logic [31:0]        w_busy;
    logic               w_ld_elig, w_ex_elig;
    logic               w_ld_grant, w_ex_grant;
    logic               w_push, w_pop;

    assign w_full  = (count_q == c_full_cnt);
    assign w_empty = (count_q == '0);
    assign w_head  = fifo_q[rd_ptr_q];

    // An entry is live when its distance from the head is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < LD_DEPTH; gi++) begin : g_entry
            logic [c_ptr_w-1:0] w_rel;
            assign w_rel           = c_ptr_w'(gi) - rd_ptr_q;
            assign w_ent_valid[gi] = ({1'b0, w_rel} < count_q);
        end
    endgenerate

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (w_ent_valid[i]) begin
                w_busy[fifo_q[i]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign rs1_busy    = w_busy[rs1_index];
    assign rs2_busy    = w_busy[rs2_index];
    assign issue_ready = !w_full;
    assign proto_err   = perr_q;

    assign w_ld_elig  = ld_valid && !w_empty;
    assign w_ex_elig  = ex_valid && !w_busy[ex_rd];
    assign w_ex_grant = rst_n && w_ex_elig && ((streak_q >= c_streak_max) || !w_ld_elig);
    assign w_ld_grant = rst_n && w_ld_elig && !w_ex_grant;
    assign w_push     = ld_issue && !w_full;
    assign w_pop      = w_ld_grant;

    assign ld_ready = w_ld_grant;
    assign ex_ready = w_ex_grant;

    always_comb begin
        rd_w     = 1'b0;
        rd_index = 5'd0;
        rd_in    = 32'd0;
        if (w_ld_grant) begin
            rd_w     = (w_head != 5'd0);
            rd_index = w_head;
            rd_in    = ld_data;
        end else if (w_ex_grant) begin
            rd_w     = (ex_rd != 5'd0);
            rd_index = ex_rd;
            rd_in    = ex_data;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        streak_d = streak_q;
        perr_d   = perr_q;
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
        // Streak only counts loads that made a ready execute result wait.
        if (w_ex_grant || !w_ex_elig) begin
            streak_d = '0;
        end else if (w_ld_grant) begin
            streak_d = streak_q + c_str_w'(1);
        end
        if ((ld_valid && w_empty) || (ld_issue && w_full)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            streak_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            streak_q <= streak_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            fifo_q[wr_ptr_q] <= ld_issue_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Purpose  : Directed and randomized bench for regfile_wb_ctrl with a
//            queue-based reference model compared on every falling edge.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_ctrl;

    localparam int LD_DEPTH      = 4;
    localparam int MAX_LD_STREAK = 4;

    logic        clk;
    logic        rst_n;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        issue_ready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic [4:0]  rs1_index, rs2_index;
    logic        rs1_busy, rs2_busy;
    logic        rd_w;
    logic [4:0]  rd_index;
    logic [31:0] rd_in;
    logic        proto_err;

    regfile_wb_ctrl #(
        .LD_DEPTH      (LD_DEPTH),
        .MAX_LD_STREAK (MAX_LD_STREAK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .issue_ready (issue_ready),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ex_ready    (ex_ready),
        .rs1_index   (rs1_index),
        .rs2_index   (rs2_index),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_w        (rd_w),
        .rd_index    (rd_index),
        .rd_in       (rd_in),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: outstanding load destinations, oldest first.
    int m_q[$];
    int m_streak = 0;
    bit m_perr   = 1'b0;

    function automatic bit m_busy(input int r);
        if (r == 0) return 1'b0;
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            bit ld_el, ex_el, g_ld, g_ex, e_w;
            int e_idx, sz;
            logic [31:0] e_dat;
            sz    = m_q.size();
            ld_el = ld_valid && (sz > 0);
            ex_el = ex_valid && !m_busy(int'(ex_rd));
            g_ex  = rst_n && ex_el && (m_streak >= MAX_LD_STREAK || !ld_el);
            g_ld  = rst_n && ld_el && !g_ex;
            e_w = 1'b0; e_idx = 0; e_dat = 32'd0;
            if (g_ld) begin
                e_w = (m_q[0] != 0); e_idx = m_q[0]; e_dat = ld_data;
            end else if (g_ex) begin
                e_w = (ex_rd != 0); e_idx = int'(ex_rd); e_dat = ex_data;
            end
            chk("issue_ready", 32'(issue_ready), 32'(sz < LD_DEPTH));
            chk("ld_ready",    32'(ld_ready),    32'(g_ld));
            chk("ex_ready",    32'(ex_ready),    32'(g_ex));
            chk("rs1_busy",    32'(rs1_busy),    32'(m_busy(int'(rs1_index))));
            chk("rs2_busy",    32'(rs2_busy),    32'(m_busy(int'(rs2_index))));
            chk("rd_w",        32'(rd_w),        32'(e_w));
            chk("proto_err",   32'(proto_err),   32'(m_perr));
            if (rst_n) begin
                chk("rd_index", 32'(rd_index), 32'(e_idx));
                chk("rd_in",    rd_in,         e_dat);
            end
            if (!rst_n) begin
                m_q.delete();
                m_streak = 0;
                m_perr   = 1'b0;
            end else begin
                if ((ld_valid && sz == 0) || (ld_issue && sz == LD_DEPTH)) m_perr = 1'b1;
                if (g_ex || !ex_el) m_streak = 0;
                else if (g_ld) m_streak++;
                if (g_ld) void'(m_q.pop_front());
                if (ld_issue && sz < LD_DEPTH) m_q.push_back(int'(ld_issue_rd));
            end
        end
    end

    task automatic idle();
        ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_data = '0;
        ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
        rs1_index = '0; rs2_index = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        model_on = 1'b1;
        tick();
        rst_n = 1'b1;

        // Execute result straight to the write port
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        #3;
        chk("t1_ex_ready", 32'(ex_ready), 32'd1);
        chk("t1_rd_w", 32'(rd_w), 32'd1);
        chk("t1_rd_index", 32'(rd_index), 32'd5);
        chk("t1_rd_in", rd_in, 32'hDEADBEEF);
        chk("t1_proto_err", 32'(proto_err), 32'd0);
        tick();

        // RAW / WAW on x7
        idle(); ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1_index = 5'd7;
        #3 chk("t2_busy_same_cycle", 32'(rs1_busy), 32'd0);
        tick();
        idle(); rs1_index = 5'd7; ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h1;
        #3;
        chk("t2_rs1_busy", 32'(rs1_busy), 32'd1);
        chk("t2_ex_blocked", 32'(ex_ready), 32'd0);
        tick();
        idle(); rs1_index = 5'd7; ld_valid = 1'b1; ld_data = 32'h12345678;
        #3;
        chk("t2_ld_ready", 32'(ld_ready), 32'd1);
        chk("t2_rd_index", 32'(rd_index), 32'd7);
        chk("t2_rd_in", rd_in, 32'h12345678);
        chk("t2_busy_during_pop", 32'(rs1_busy), 32'd1);
        tick();
        idle(); rs1_index = 5'd7;
        #3 chk("t2_busy_cleared", 32'(rs1_busy), 32'd0);
        tick();

        // Fill the FIFO, then drain in order
        for (int i = 1; i <= 4; i++) begin
            idle(); ld_issue = 1'b1; ld_issue_rd = 5'(i);
            tick();
        end
        for (int i = 1; i <= 4; i++) begin
            idle(); ld_valid = 1'b1; ld_data = 32'(i * 16);
            #3;
            chk("t3_issue_ready", 32'(issue_ready), (i == 1) ? 32'd0 : 32'd1);
            chk("t3_rd_index", 32'(rd_index), 32'(i));
            tick();
        end

        // Load streak limit with a waiting execute result to x9
        for (int i = 0; i < 4; i++) begin
            idle(); ld_issue = 1'b1; ld_issue_rd = 5'(10 + i);
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            idle();
            ld_valid = 1'b1; ld_data = 32'hA000 + 32'(c);
            ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'hE9;
            if (c >= 1 && c <= 3) begin
                ld_issue = 1'b1; ld_issue_rd = 5'(20 + c);
            end
            #3;
            chk("t4_ld_ready", 32'(ld_ready), (c == 4) ? 32'd0 : 32'd1);
            chk("t4_ex_ready", 32'(ex_ready), (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            idle(); ld_valid = 1'b1;
            tick();
        end

        // Load to x0, then a response with nothing outstanding
        idle(); ld_issue = 1'b1; ld_issue_rd = 5'd0;
        tick();
        idle(); ld_valid = 1'b1; ld_data = 32'hFFFFFFFF;
        #3;
        chk("t5_ld_ready", 32'(ld_ready), 32'd1);
        chk("t5_rd_w", 32'(rd_w), 32'd0);
        tick();
        idle(); ld_valid = 1'b1;
        #3;
        chk("t5_empty_ld_ready", 32'(ld_ready), 32'd0);
        chk("t5_perr_not_yet", 32'(proto_err), 32'd0);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #3 chk("t5_perr_sticky", 32'(proto_err), 32'd1);
            tick();
        end

        // Reset with two tags outstanding
        idle(); ld_issue = 1'b1; ld_issue_rd = 5'd3;
        tick();
        idle(); ld_issue = 1'b1; ld_issue_rd = 5'd4;
        tick();
        idle(); rst_n = 1'b0; rs1_index = 5'd3; rs2_index = 5'd4;
        ex_valid = 1'b1; ex_rd = 5'd5; ld_valid = 1'b1;
        #3;
        chk("t6_rd_w_in_reset", 32'(rd_w), 32'd0);
        chk("t6_ld_ready_in_reset", 32'(ld_ready), 32'd0);
        chk("t6_ex_ready_in_reset", 32'(ex_ready), 32'd0);
        tick();
        #3;
        chk("t6_issue_ready", 32'(issue_ready), 32'd1);
        chk("t6_rs1_busy", 32'(rs1_busy), 32'd0);
        chk("t6_rs2_busy", 32'(rs2_busy), 32'd0);
        chk("t6_perr_clear", 32'(proto_err), 32'd0);
        tick();
        idle(); rst_n = 1'b1; ld_valid = 1'b1;
        #3 chk("t6_stale_resp", 32'(ld_ready), 32'd0);
        tick();
        idle();
        #3 chk("t6_stale_perr", 32'(proto_err), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Randomized traffic, narrow register range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            ld_issue    = ($urandom_range(0, 2) == 0);
            ld_issue_rd = 5'($urandom_range(0, 7));
            ld_valid    = ($urandom_range(0, 1) == 0);
            ld_data     = $urandom;
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_rd       = 5'($urandom_range(0, 7));
            ex_data     = $urandom;
            rs1_index   = 5'($urandom_range(0, 7));
            rs2_index   = 5'($urandom_range(0, 7));
            tick();
        end

        idle();
        tick();
        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
